// File: rtl/score_writer_if.sv
// UART byte input and regfile/length write bus for score_writer.
interface score_writer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] addr_c;
  logic [11:0] data_c;
  logic        wen_c;
  logic        len_we;
  logic [2:0]  len_sel;
  logic [7:0]  len_val;

  modport master (
    output rx_data, rx_valid,
    input  addr_c, data_c, wen_c, len_we, len_sel, len_val
  );

  modport slave (
    input  rx_data, rx_valid,
    output addr_c, data_c, wen_c, len_we, len_sel, len_val
  );
endinterface

// File: rtl/score_writer.sv
// Parses framed score uploads from a UART byte stream into regfile note writes
// and a per-slot song length commit guarded by an XOR checksum.
module score_writer #(
  parameter int unsigned TIMEOUT = 1000000,
  parameter logic [7:0]  HEADER  = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic busy,
  output logic done,
  output logic err,
  score_writer_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StSel, StLen, StNoteHi, StNoteLo, StChk} state_e;

  state_e        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    idx_q, idx_d;
  logic [3:0]    hi_q, hi_d;
  logic [7:0]    xor_q, xor_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   addr_q, addr_d;
  logic [11:0]   data_q, data_d;
  logic          wen_q, wen_d;
  logic          len_we_q, len_we_d;
  logic [2:0]    len_sel_q, len_sel_d;
  logic [7:0]    len_val_q, len_val_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic accept;
  logic [7:0] b;
  logic [7:0] idx_inc;

  assign accept  = bus.rx_valid && en;
  assign b       = bus.rx_data;
  assign idx_inc = idx_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    count_d   = count_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    xor_d     = xor_q;
    tmo_d     = (state_q == StIdle) ? '0 : tmo_q + TW'(1);
    addr_d    = addr_q;
    data_d    = data_q;
    wen_d     = 1'b0;
    len_we_d  = 1'b0;
    len_sel_d = len_sel_q;
    len_val_d = len_val_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (state_q != StIdle && !en) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end else if (accept) begin
      // A consumed byte always wins over a simultaneous timeout expiry.
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (b == HEADER) begin
            state_d = StSel;
            xor_d   = 8'h00;
          end
        end
        StSel: begin
          if (b <= 8'd7) begin
            sel_d   = b[2:0];
            xor_d   = xor_q ^ b;
            state_d = StLen;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        StLen: begin
          if (b == 8'd0) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            count_d = b;
            idx_d   = 8'd0;
            xor_d   = xor_q ^ b;
            state_d = StNoteHi;
          end
        end
        StNoteHi: begin
          hi_d    = b[3:0];
          xor_d   = xor_q ^ b;
          state_d = StNoteLo;
        end
        StNoteLo: begin
          wen_d   = 1'b1;
          addr_d  = {5'b0, sel_q, idx_q};
          data_d  = {hi_q, b};
          xor_d   = xor_q ^ b;
          idx_d   = idx_inc;
          state_d = (idx_inc == count_q) ? StChk : StNoteHi;
        end
        StChk: begin
          // Notes already written stay; only the length commit is withheld on mismatch.
          if (b == xor_q) begin
            len_we_d  = 1'b1;
            len_sel_d = sel_q;
            len_val_d = count_q;
            done_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && tmo_q == TMO_LAST) begin
      err_d   = 1'b1;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      hi_q      <= '0;
      xor_q     <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wen_q     <= 1'b0;
      len_we_q  <= 1'b0;
      len_sel_q <= '0;
      len_val_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      hi_q      <= hi_d;
      xor_q     <= xor_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wen_q     <= wen_d;
      len_we_q  <= len_we_d;
      len_sel_q <= len_sel_d;
      len_val_q <= len_val_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign err         = err_q;
  assign bus.addr_c  = addr_q;
  assign bus.data_c  = data_q;
  assign bus.wen_c   = wen_q;
  assign bus.len_we  = len_we_q;
  assign bus.len_sel = len_sel_q;
  assign bus.len_val = len_val_q;

endmodule
